// File: rtl/soin_btb_bimodal_predictor_if.sv
// rtl/soin_btb_bimodal_predictor_if.sv - fetch/execute bundle for the tagged BTB bimodal predictor
//
// master: fetch/execute side (drives PC, instruction, redirect, stall and resolved-branch update;
//         receives prediction, meta and ready).
// slave : predictor side (the reverse).
// META_W = RAS_DEPTH_L+1+CTR_BITS+INDEX_BITS, layout {ras_ptr, hit, ctr, index}.
interface soin_btb_bimodal_predictor_if #(
    parameter int INDEX_BITS  = 8,
    parameter int CTR_BITS    = 2,
    parameter int RAS_DEPTH_L = 4
);
    localparam int META_W = RAS_DEPTH_L + 1 + CTR_BITS + INDEX_BITS;

    logic              soin_bpredictor_stall;
    logic [31:0]       fetch_bpredictor_PC;
    logic [31:0]       fetch_bpredictor_inst;
    logic              fetch_redirect;
    logic [31:0]       fetch_redirect_PC;
    logic              bpredictor_fetch_p_dir;
    logic [31:0]       bpredictor_fetch_p_target;
    logic [META_W-1:0] bpredictor_fetch_meta;
    logic              bpredictor_ready;
    logic              execute_bpredictor_update;
    logic [31:0]       execute_bpredictor_PC;
    logic [31:0]       execute_bpredictor_target;
    logic              execute_bpredictor_dir;
    logic              execute_bpredictor_miss;
    logic [META_W-1:0] execute_bpredictor_meta;
    logic              execute_bpredictor_recover_ras;

    modport master (
        output soin_bpredictor_stall, fetch_bpredictor_PC, fetch_bpredictor_inst,
        output fetch_redirect, fetch_redirect_PC,
        output execute_bpredictor_update, execute_bpredictor_PC, execute_bpredictor_target,
        output execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_meta,
        output execute_bpredictor_recover_ras,
        input  bpredictor_fetch_p_dir, bpredictor_fetch_p_target, bpredictor_fetch_meta,
        input  bpredictor_ready
    );

    modport slave (
        input  soin_bpredictor_stall, fetch_bpredictor_PC, fetch_bpredictor_inst,
        input  fetch_redirect, fetch_redirect_PC,
        input  execute_bpredictor_update, execute_bpredictor_PC, execute_bpredictor_target,
        input  execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_meta,
        input  execute_bpredictor_recover_ras,
        output bpredictor_fetch_p_dir, bpredictor_fetch_p_target, bpredictor_fetch_meta,
        output bpredictor_ready
    );
endinterface

// File: rtl/soin_btb_bimodal_predictor.sv
// rtl/soin_btb_bimodal_predictor.sv - tagged direct-mapped BTB with saturating direction counters
//
// Ports: clk, reset (synchronous, active-low), bp (soin_btb_bimodal_predictor_if.slave):
//   fetch side  - stall, PC, inst, redirect/redirect_PC in; p_dir, p_target, meta, ready out
//   execute side - resolved branch update (PC, target, dir, miss, meta, recover_ras) in
// Optional feature: define SOIN_BP_RAS_EN to add a circular return address stack.
module soin_btb_bimodal_predictor #(
    parameter int INDEX_BITS  = 8,
    parameter int TAG_BITS    = 8,
    parameter int CTR_BITS    = 2,
    parameter int RAS_DEPTH_L = 4
) (
    input logic                        clk,
    input logic                        reset,
    soin_btb_bimodal_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int META_W  = RAS_DEPTH_L + 1 + CTR_BITS + INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [31:0]           pc_r_q, pc_r_d;
    logic                  run;

    logic                  tbl_valid_q [ENTRIES];
    logic [TAG_BITS-1:0]   tbl_tag_q   [ENTRIES];
    logic [29:0]           tbl_tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0]   tbl_ctr_q   [ENTRIES];

    // Registered read port; rd_live marks data captured while RUN so stale
    // pre-reset contents read during the last INIT cycle can never hit.
    logic [INDEX_BITS-1:0] rd_idx;
    logic                  rd_live_q, rd_live_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [TAG_BITS-1:0]   rd_tag_q, rd_tag_d;
    logic [29:0]           rd_tgt_q, rd_tgt_d;
    logic [CTR_BITS-1:0]   rd_ctr_q, rd_ctr_d;

    logic [INDEX_BITS-1:0] wr_idx;
    logic                  wr_vt_en, wr_ctr_en, wr_tgt_en, wr_valid;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [29:0]           wr_tgt;
    logic [CTR_BITS-1:0]   wr_ctr;

    logic [INDEX_BITS-1:0]  m_idx;
    logic [CTR_BITS-1:0]    m_ctr;
    logic                   m_hit;
    logic [RAS_DEPTH_L-1:0] m_ras;

    logic [RAS_DEPTH_L-1:0] ras_ptr;
    logic                   ret_pred;
    logic [31:0]            ret_target;

    logic                   hit, p_dir;
    logic [31:0]            p_target;
    logic [META_W-1:0]      meta;

    assign run   = (state_q == ST_RUN);
    assign m_idx = bp.execute_bpredictor_meta[INDEX_BITS-1:0];
    assign m_ctr = bp.execute_bpredictor_meta[INDEX_BITS +: CTR_BITS];
    assign m_hit = bp.execute_bpredictor_meta[INDEX_BITS+CTR_BITS];
    assign m_ras = bp.execute_bpredictor_meta[META_W-1 -: RAS_DEPTH_L];

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (&init_idx_q) state_d = ST_RUN;
        end
    end

    always_comb begin
        rd_idx     = bp.soin_bpredictor_stall ? pc_r_q[INDEX_BITS+1:2]
                                              : bp.fetch_bpredictor_PC[INDEX_BITS+1:2];
        pc_r_d     = bp.soin_bpredictor_stall ? pc_r_q : bp.fetch_bpredictor_PC;
        rd_live_d  = run;
        rd_valid_d = tbl_valid_q[rd_idx];
        rd_tag_d   = tbl_tag_q[rd_idx];
        rd_tgt_d   = tbl_tgt_q[rd_idx];
        rd_ctr_d   = tbl_ctr_q[rd_idx];
    end

    // Table write: INIT clear sweep, or a resolved-branch update in RUN.
    // Counter arithmetic uses the counter value captured at lookup time (meta).
    always_comb begin
        wr_idx    = init_idx_q;
        wr_vt_en  = 1'b0;
        wr_ctr_en = 1'b0;
        wr_tgt_en = 1'b0;
        wr_valid  = 1'b0;
        wr_tag    = '0;
        wr_tgt    = bp.execute_bpredictor_target[31:2];
        wr_ctr    = CTR_WEAK_NT;
        if (!reset) begin
            wr_vt_en = 1'b0;
        end else if (state_q == ST_INIT) begin
            wr_vt_en  = 1'b1;
            wr_ctr_en = 1'b1;
        end else if (bp.execute_bpredictor_update) begin
            wr_idx = m_idx;
            if (m_hit) begin
                wr_ctr_en = 1'b1;
                wr_tgt_en = bp.execute_bpredictor_miss & bp.execute_bpredictor_dir;
                if (bp.execute_bpredictor_dir)
                    wr_ctr = (m_ctr == CTR_MAX) ? CTR_MAX : m_ctr + 1'b1;
                else
                    wr_ctr = (m_ctr == '0) ? '0 : m_ctr - 1'b1;
            end else if (bp.execute_bpredictor_dir) begin
                wr_vt_en  = 1'b1;
                wr_ctr_en = 1'b1;
                wr_tgt_en = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = bp.execute_bpredictor_PC[TAG_HI:TAG_LO];
                wr_ctr    = CTR_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vt_en) begin
            tbl_valid_q[wr_idx] <= wr_valid;
            tbl_tag_q[wr_idx]   <= wr_tag;
        end
        if (wr_ctr_en) tbl_ctr_q[wr_idx] <= wr_ctr;
        if (wr_tgt_en) tbl_tgt_q[wr_idx] <= wr_tgt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            pc_r_q     <= '0;
            rd_live_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= '0;
            rd_tgt_q   <= '0;
            rd_ctr_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            pc_r_q     <= pc_r_d;
            rd_live_q  <= rd_live_d;
            rd_valid_q <= rd_valid_d;
            rd_tag_q   <= rd_tag_d;
            rd_tgt_q   <= rd_tgt_d;
            rd_ctr_q   <= rd_ctr_d;
        end
    end

`ifdef SOIN_BP_RAS_EN
    localparam int RAS_N = 1 << RAS_DEPTH_L;

    logic [31:0]            ras_q [RAS_N];
    logic [RAS_DEPTH_L-1:0] ras_ptr_q, ras_ptr_d;
    logic [5:0]             opc, fn;
    logic                   is_call, is_ret, ras_act, ras_recover, ras_push;

    always_comb begin
        opc         = bp.fetch_bpredictor_inst[5:0];
        fn          = bp.fetch_bpredictor_inst[16:11];
        is_call     = (opc == 6'h00) || ((opc == 6'h3A) && (fn == 6'h1D));
        is_ret      = (opc == 6'h3A) && (fn == 6'h05);
        ras_act     = run && !bp.soin_bpredictor_stall && !bp.fetch_redirect;
        ras_recover = run && bp.execute_bpredictor_update && bp.execute_bpredictor_recover_ras;
        ras_push    = ras_act && is_call && !ras_recover;
        ras_ptr_d   = ras_ptr_q;
        if (ras_recover)
            ras_ptr_d = m_ras;
        else if (ras_act && is_call)
            ras_ptr_d = ras_ptr_q + 1'b1;
        else if (ras_act && is_ret)
            ras_ptr_d = ras_ptr_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) ras_ptr_q <= '0;
        else        ras_ptr_q <= ras_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (ras_push) ras_q[ras_ptr_q] <= pc_r_q + 32'd4;
    end

    assign ras_ptr    = ras_ptr_q;
    assign ret_pred   = run && is_ret;
    assign ret_target = ras_q[ras_ptr_q - 1'b1];

    logic unused_bits;
    assign unused_bits = ^{bp.execute_bpredictor_PC, bp.execute_bpredictor_target[1:0]};
`else
    assign ras_ptr    = '0;
    assign ret_pred   = 1'b0;
    assign ret_target = '0;

    logic unused_bits;
    assign unused_bits = ^{bp.execute_bpredictor_PC, bp.execute_bpredictor_target[1:0],
                           bp.fetch_bpredictor_inst, bp.execute_bpredictor_recover_ras, m_ras};
`endif

    // Priority: redirect overrides everything, then RAS return, then a taken table hit.
    always_comb begin
        hit      = run & rd_live_q & rd_valid_q & (rd_tag_q == pc_r_q[TAG_HI:TAG_LO]);
        p_dir    = hit & rd_ctr_q[CTR_BITS-1];
        p_target = pc_r_q + 32'd4;
        if (p_dir) p_target = {rd_tgt_q, 2'b00};
        if (ret_pred) begin
            p_dir    = 1'b1;
            p_target = ret_target;
        end
        if (bp.fetch_redirect) begin
            p_dir    = 1'b0;
            p_target = bp.fetch_redirect_PC;
        end
        meta = run ? {ras_ptr, hit, rd_ctr_q, pc_r_q[INDEX_BITS+1:2]} : '0;
    end

    assign bp.bpredictor_fetch_p_dir    = p_dir;
    assign bp.bpredictor_fetch_p_target = p_target;
    assign bp.bpredictor_fetch_meta     = meta;
    assign bp.bpredictor_ready          = run;
endmodule

// File: tb/tb_soin_btb_bimodal_predictor.sv
// tb/tb_soin_btb_bimodal_predictor.sv - directed vector bench for soin_btb_bimodal_predictor
module tb_soin_btb_bimodal_predictor;
    localparam int INDEX_BITS  = 8;
    localparam int TAG_BITS    = 8;
    localparam int CTR_BITS    = 2;
    localparam int RAS_DEPTH_L = 4;
    localparam int NV          = 19;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    soin_btb_bimodal_predictor_if #(
        .INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS), .RAS_DEPTH_L(RAS_DEPTH_L)
    ) bp_if ();

    soin_btb_bimodal_predictor #(
        .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS), .RAS_DEPTH_L(RAS_DEPTH_L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if)
    );

    typedef struct {
        bit          upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        bit          udir;
        bit          umiss;
        bit          uhit;
        logic [1:0]  uctr;
        logic [31:0] lpc;
        bit          edir;
        logic [31:0] etgt;
        bit          ehit;
        logic [1:0]  ectr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mkv(bit upd, logic [31:0] upc, logic [31:0] utgt, bit udir, bit umiss,
                                 bit uhit, logic [1:0] uctr, logic [31:0] lpc, bit edir,
                                 logic [31:0] etgt, bit ehit, logic [1:0] ectr);
        vec_t v;
        v.upd = upd; v.upc = upc; v.utgt = utgt; v.udir = udir; v.umiss = umiss;
        v.uhit = uhit; v.uctr = uctr; v.lpc = lpc; v.edir = edir; v.etgt = etgt;
        v.ehit = ehit; v.ectr = ectr;
        return v;
    endfunction

    function automatic logic [14:0] mk_meta(logic [3:0] ras, logic hit, logic [1:0] ctr, logic [31:0] pc);
        return {ras, hit, ctr, pc[9:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp_if.soin_bpredictor_stall          = 1'b0;
        bp_if.fetch_bpredictor_PC            = 32'h0;
        bp_if.fetch_bpredictor_inst          = 32'h13;
        bp_if.fetch_redirect                 = 1'b0;
        bp_if.fetch_redirect_PC              = 32'h0;
        bp_if.execute_bpredictor_update      = 1'b0;
        bp_if.execute_bpredictor_PC          = 32'h0;
        bp_if.execute_bpredictor_target      = 32'h0;
        bp_if.execute_bpredictor_dir         = 1'b0;
        bp_if.execute_bpredictor_miss        = 1'b0;
        bp_if.execute_bpredictor_meta        = '0;
        bp_if.execute_bpredictor_recover_ras = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        //        upd upc           utgt          d  m  h  c  lpc           edir etgt          eh ectr
        vecs[0]  = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      0, 32'h104,      0, 1);
        vecs[1]  = mkv(1, 32'h100,      32'h400,      1, 1, 0, 1, 32'h100,      0, 32'h104,      0, 1);
        vecs[2]  = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      1, 32'h400,      1, 2);
        vecs[3]  = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h500,      0, 32'h504,      0, 2);
        vecs[4]  = mkv(1, 32'h100,      32'h400,      1, 0, 1, 2, 32'h100,      1, 32'h400,      1, 2);
        vecs[5]  = mkv(1, 32'h100,      32'h400,      1, 0, 1, 3, 32'h100,      1, 32'h400,      1, 3);
        vecs[6]  = mkv(1, 32'h100,      32'hDEAD0,    0, 1, 1, 3, 32'h100,      1, 32'h400,      1, 3);
        vecs[7]  = mkv(1, 32'h100,      32'hDEAD0,    0, 1, 1, 2, 32'h100,      1, 32'h400,      1, 2);
        vecs[8]  = mkv(1, 32'h100,      32'hDEAD0,    0, 1, 1, 1, 32'h100,      0, 32'h104,      1, 1);
        vecs[9]  = mkv(1, 32'h100,      32'hDEAD0,    0, 1, 1, 0, 32'h100,      0, 32'h104,      1, 0);
        vecs[10] = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      0, 32'h104,      1, 0);
        vecs[11] = mkv(1, 32'h100,      32'h800,      1, 1, 1, 0, 32'h100,      0, 32'h104,      1, 0);
        vecs[12] = mkv(1, 32'h100,      32'hC00,      1, 0, 1, 1, 32'h100,      0, 32'h104,      1, 1);
        vecs[13] = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      1, 32'h800,      1, 2);
        vecs[14] = mkv(1, 32'h904,      32'hA00,      0, 1, 0, 1, 32'h904,      0, 32'h908,      0, 1);
        vecs[15] = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h904,      0, 32'h908,      0, 1);
        vecs[16] = mkv(1, 32'h500,      32'h600,      1, 1, 0, 2, 32'hFFFFFFFC, 0, 32'h0,        0, 1);
        vecs[17] = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h500,      1, 32'h600,      1, 2);
        vecs[18] = mkv(0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      0, 32'h104,      0, 2);

        idle();
        reset = 1'b0;
        step(); step(); step();
        check("rst_ready", {31'b0, bp_if.bpredictor_ready}, 32'h0);
        check("rst_p_dir", {31'b0, bp_if.bpredictor_fetch_p_dir}, 32'h0);
        check("rst_p_target", bp_if.bpredictor_fetch_p_target, 32'h4);
        check("rst_meta", {17'b0, bp_if.bpredictor_fetch_meta}, 32'h0);

        reset = 1'b1;
        n = 0;
        bad = 0;
        while (bp_if.bpredictor_ready !== 1'b1 && n < 1000) begin
            if (bp_if.bpredictor_fetch_p_target !== 32'h4 || bp_if.bpredictor_fetch_p_dir !== 1'b0 ||
                bp_if.bpredictor_fetch_meta !== '0) bad++;
            n++;
            step();
        end
        check("init_cycles", n, 256);
        check("init_outputs_bad_cycles", bad, 0);

        for (int i = 0; i < NV; i++) begin
            bp_if.execute_bpredictor_update = vecs[i].upd;
            bp_if.execute_bpredictor_PC     = vecs[i].upc;
            bp_if.execute_bpredictor_target = vecs[i].utgt;
            bp_if.execute_bpredictor_dir    = vecs[i].udir;
            bp_if.execute_bpredictor_miss   = vecs[i].umiss;
            bp_if.execute_bpredictor_meta   = mk_meta(4'h0, vecs[i].uhit, vecs[i].uctr, vecs[i].upc);
            bp_if.fetch_bpredictor_PC       = vecs[i].lpc;
            step();
            bp_if.execute_bpredictor_update = 1'b0;
            check($sformatf("v%0d_p_dir", i), {31'b0, bp_if.bpredictor_fetch_p_dir}, {31'b0, vecs[i].edir});
            check($sformatf("v%0d_p_target", i), bp_if.bpredictor_fetch_p_target, vecs[i].etgt);
            check($sformatf("v%0d_meta", i), {17'b0, bp_if.bpredictor_fetch_meta},
                  {17'b0, mk_meta(4'h0, vecs[i].ehit, vecs[i].ectr, vecs[i].lpc)});
        end

        bp_if.fetch_bpredictor_PC = 32'h500;
        step();
        check("pre_redirect_target", bp_if.bpredictor_fetch_p_target, 32'h600);
        bp_if.fetch_redirect    = 1'b1;
        bp_if.fetch_redirect_PC = 32'h1234_5678;
        #1;
        check("redirect_target", bp_if.bpredictor_fetch_p_target, 32'h1234_5678);
        check("redirect_p_dir", {31'b0, bp_if.bpredictor_fetch_p_dir}, 32'h0);
        bp_if.fetch_redirect        = 1'b0;
        bp_if.soin_bpredictor_stall = 1'b1;
        bp_if.fetch_bpredictor_PC   = 32'h904;
        for (int s = 0; s < 2; s++) begin
            step();
            check($sformatf("stall%0d_p_dir", s), {31'b0, bp_if.bpredictor_fetch_p_dir}, 32'h1);
            check($sformatf("stall%0d_target", s), bp_if.bpredictor_fetch_p_target, 32'h600);
            check($sformatf("stall%0d_meta", s), {17'b0, bp_if.bpredictor_fetch_meta},
                  {17'b0, mk_meta(4'h0, 1'b1, 2'd2, 32'h500)});
        end
        bp_if.soin_bpredictor_stall = 1'b0;
        step();
        check("unstall_target", bp_if.bpredictor_fetch_p_target, 32'h908);

        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        check("midrst_ready", {31'b0, bp_if.bpredictor_ready}, 32'h0);
        check("midrst_target", bp_if.bpredictor_fetch_p_target, 32'h4);
        n = 0;
        while (bp_if.bpredictor_ready !== 1'b1 && n < 1000) begin
            if (n == 250) begin
                bp_if.execute_bpredictor_update = 1'b1;
                bp_if.execute_bpredictor_PC     = 32'h400;
                bp_if.execute_bpredictor_target = 32'h700;
                bp_if.execute_bpredictor_dir    = 1'b1;
                bp_if.execute_bpredictor_miss   = 1'b1;
                bp_if.execute_bpredictor_meta   = mk_meta(4'h0, 1'b0, 2'd1, 32'h400);
            end else begin
                bp_if.execute_bpredictor_update = 1'b0;
            end
            n++;
            step();
        end
        bp_if.execute_bpredictor_update = 1'b0;
        check("midrst_init_cycles", n, 256);
        bp_if.fetch_bpredictor_PC = 32'h500;
        step();
        check("midrst_cleared_meta", {17'b0, bp_if.bpredictor_fetch_meta},
              {17'b0, mk_meta(4'h0, 1'b0, 2'd1, 32'h500)});
        check("midrst_cleared_target", bp_if.bpredictor_fetch_p_target, 32'h504);
        bp_if.fetch_bpredictor_PC = 32'h400;
        step();
        check("init_update_ignored", {17'b0, bp_if.bpredictor_fetch_meta},
              {17'b0, mk_meta(4'h0, 1'b0, 2'd1, 32'h400)});

`ifdef SOIN_BP_RAS_EN
        bp_if.fetch_bpredictor_PC = 32'h200;
        step();
        bp_if.fetch_bpredictor_inst = 32'h0;
        bp_if.fetch_bpredictor_PC   = 32'h300;
        step();
        bp_if.fetch_bpredictor_inst = 32'h283A;
        #1;
        check("ras_ret_target", bp_if.bpredictor_fetch_p_target, 32'h204);
        check("ras_ret_p_dir", {31'b0, bp_if.bpredictor_fetch_p_dir}, 32'h1);
        check("ras_ptr_after_call", {28'b0, bp_if.bpredictor_fetch_meta[14:11]}, 32'h1);
        step();
        bp_if.fetch_bpredictor_inst = 32'h13;
        #1;
        check("ras_ptr_after_ret", {28'b0, bp_if.bpredictor_fetch_meta[14:11]}, 32'h0);
        bp_if.fetch_bpredictor_inst = 32'h0;
        for (int c = 0; c < 17; c++) step();
        bp_if.fetch_bpredictor_inst = 32'h13;
        #1;
        check("ras_ptr_wrap", {28'b0, bp_if.bpredictor_fetch_meta[14:11]}, 32'h1);
        bp_if.execute_bpredictor_update      = 1'b1;
        bp_if.execute_bpredictor_recover_ras = 1'b1;
        bp_if.execute_bpredictor_dir         = 1'b0;
        bp_if.execute_bpredictor_meta        = mk_meta(4'h3, 1'b0, 2'd0, 32'h0);
        step();
        bp_if.execute_bpredictor_update      = 1'b0;
        bp_if.execute_bpredictor_recover_ras = 1'b0;
        #1;
        check("ras_recover_ptr", {28'b0, bp_if.bpredictor_fetch_meta[14:11]}, 32'h3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
